cpu_ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding stage directly upstream of the execute-stage ALU.
- Captures decoded operands and ALU op from decode, and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, stalls decode and inserts a bubble.
- Drives the ALU's in_a, in_b and op_sel inputs.

---
 rtl/cpu_ex_operand_stage.sv | 166 ++++++++++++++++
 tb/tb_cpu_ex_operand_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// cpu_ex_operand_stage
//
// This is the ID/EX pipeline register that sits in front of the execute-stage ALU.
// It also forwards operands so that RAW hazards resolve without waiting.
//
// Each cycle it captures the decoded instruction. It then supplies the ALU
// operands, forwarding results that are still in flight in MEM or WB. When
// the EX stage holds a load whose destination the next instruction reads, it
// stalls decode and inserts a one-cycle bubble.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   id_*              decoded instruction fields and register-file reads
//   mem_rd_*, mem_result  MEM-stage destination/result (forward source 1)
//   wb_rd_*,  wb_result   WB-stage destination/data (forward source 2)
//   ex_hold           downstream stall, freezes the EX contents
//   flush             kills the instruction that would enter EX
//   id_stall          decode must hold its current instruction
//   ex_valid          EX holds a valid instruction
//   ex_in_a, ex_in_b  ALU operands (after source select and forwarding)
//   ex_op_sel         ALU operation select
//   ex_rs2_fwd        forwarded rs2 value (store data)
//   ex_rd_addr        destination register of the EX instruction
//   ex_rd_we, ex_is_load  write-enable / load flag, qualified by ex_valid
// -----------------------------------------------------------------------------
module cpu_ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic                      id_src_a_sel,
    input  logic                      id_src_b_sel,
    input  logic [3:0]                id_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_rd_we,
    input  logic                      id_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                      mem_rd_we,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic                      wb_rd_we,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    input  logic                      ex_hold,
    input  logic                      flush,
    output logic                      id_stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_in_a,
    output logic [DATA_WIDTH-1:0]     ex_in_b,
    output logic [3:0]                ex_op_sel,
    output logic [DATA_WIDTH-1:0]     ex_rs2_fwd,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_rd_we,
    output logic                      ex_is_load
);

    logic                      valid_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
    logic [DATA_WIDTH-1:0]     rs1_data_q;
    logic [DATA_WIDTH-1:0]     rs2_data_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic                      src_a_sel_q;
    logic                      src_b_sel_q;
    logic [3:0]                alu_op_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      rd_we_q;
    logic                      is_load_q;

    logic                      load_use;
    logic [DATA_WIDTH-1:0]     fwd_rs1;
    logic [DATA_WIDTH-1:0]     fwd_rs2;

    // A load in EX only has its data at the end of MEM, so a dependent
    // instruction in decode must wait one cycle. Both source indices are
    // compared whether or not the instruction actually uses them. This can
    // stall when no stall is needed, but it never misses a real hazard.
    assign load_use = id_valid & valid_q & is_load_q
                    & (rd_addr_q != '0)
                    & ((rd_addr_q == id_rs1_addr) | (rd_addr_q == id_rs2_addr));

    assign id_stall = load_use | ex_hold;

    // Operand forwarding works from the registered source indices. MEM holds
    // the younger result, so it takes priority over WB. x0 is hard-wired to
    // zero and is never overridden.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        fwd_rs2 = rs2_data_q;
        if (rs1_addr_q != '0) begin
            if (mem_rd_we && (mem_rd_addr == rs1_addr_q)) begin
                fwd_rs1 = mem_result;
            end else if (wb_rd_we && (wb_rd_addr == rs1_addr_q)) begin
                fwd_rs1 = wb_result;
            end
        end
        if (rs2_addr_q != '0) begin
            if (mem_rd_we && (mem_rd_addr == rs2_addr_q)) begin
                fwd_rs2 = mem_result;
            end else if (wb_rd_we && (wb_rd_addr == rs2_addr_q)) begin
                fwd_rs2 = wb_result;
            end
        end
    end

    // Pipeline register update.
    // While held, the data registers reload their forwarded value. A result
    // that passes through WB during the hold is then kept after WB retires it.
    // A flush or a load-use bubble only needs to clear valid; the other
    // fields are left as they are.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            src_a_sel_q <= 1'b0;
            src_b_sel_q <= 1'b0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
            is_load_q   <= 1'b0;
        end else if (ex_hold) begin
            rs1_data_q  <= fwd_rs1;
            rs2_data_q  <= fwd_rs2;
        end else if (flush || load_use) begin
            valid_q     <= 1'b0;
        end else begin
            valid_q     <= id_valid;
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            pc_q        <= id_pc;
            src_a_sel_q <= id_src_a_sel;
            src_b_sel_q <= id_src_b_sel;
            alu_op_q    <= id_alu_op;
            rd_addr_q   <= id_rd_addr;
            rd_we_q     <= id_rd_we;
            is_load_q   <= id_is_load;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_in_a    = src_a_sel_q ? pc_q  : fwd_rs1;
    assign ex_in_b    = src_b_sel_q ? imm_q : fwd_rs2;
    assign ex_op_sel  = alu_op_q;
    assign ex_rs2_fwd = fwd_rs2;
    assign ex_rd_addr = rd_addr_q;
    assign ex_rd_we   = rd_we_q & valid_q;
    assign ex_is_load = is_load_q & valid_q;

endmodule

// File: tb/tb_cpu_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_cpu_ex_operand_stage
//
// This bench drives cpu_ex_operand_stage with directed scenarios and then a
// randomized run. It compares every output against a transaction-level model
// of the instruction that currently sits in EX.
// -----------------------------------------------------------------------------
module tb_cpu_ex_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic          id_src_a_sel, id_src_b_sel, id_rd_we, id_is_load;
    logic [3:0]    id_alu_op;
    logic [AW-1:0] mem_rd_addr, wb_rd_addr;
    logic          mem_rd_we, wb_rd_we;
    logic [DW-1:0] mem_result, wb_result;
    logic          ex_hold, flush;
    logic          id_stall, ex_valid, ex_rd_we, ex_is_load;
    logic [DW-1:0] ex_in_a, ex_in_b, ex_rs2_fwd;
    logic [3:0]    ex_op_sel;
    logic [AW-1:0] ex_rd_addr;

    int compared   = 0;
    int mismatched = 0;

    // Instruction sitting in EX as the model sees it.
    // known=0 means the fields are don't-care, which is the case after a bubble.
    typedef struct {
        logic          known;
        logic          valid;
        logic [AW-1:0] rs1, rs2, rd;
        logic [DW-1:0] d1, d2, imm, pc;
        logic          sa, sb, we, ld;
        logic [3:0]    op;
    } ex_model_t;

    ex_model_t m;

    always #5 clk = ~clk;

    cpu_ex_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_pc(id_pc), .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
        .id_alu_op(id_alu_op), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_result(wb_result),
        .ex_hold(ex_hold), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b),
        .ex_op_sel(ex_op_sel), .ex_rs2_fwd(ex_rs2_fwd), .ex_rd_addr(ex_rd_addr),
        .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load)
    );

    // The value a source register really holds right now.
    // This is the youngest in-flight writer, or the register-file copy.
    function automatic logic [DW-1:0] modelFwd(input logic [AW-1:0] rs, input logic [DW-1:0] regval);
        if (rs == 0) return regval;
        if (mem_rd_we && mem_rd_addr == rs) return mem_result;
        if (wb_rd_we && wb_rd_addr == rs) return wb_result;
        return regval;
    endfunction

    // Decode reads a register that the load in EX has not produced yet.
    function automatic logic modelLoadUse();
        return id_valid && m.valid && m.ld && (m.rd != 0)
            && (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
    endfunction

    task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("[TB] %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Samples the outputs on the falling edge and compares them with the model.
    task automatic checkOutput();
        @(negedge clk);
        checkVal("id_stall",   {31'd0, id_stall},   {31'd0, ex_hold | modelLoadUse()});
        checkVal("ex_valid",   {31'd0, ex_valid},   {31'd0, m.valid});
        checkVal("ex_rd_we",   {31'd0, ex_rd_we},   {31'd0, m.valid & m.we});
        checkVal("ex_is_load", {31'd0, ex_is_load}, {31'd0, m.valid & m.ld});
        if (m.known) begin
            checkVal("ex_in_a",    ex_in_a,    m.sa ? m.pc  : modelFwd(m.rs1, m.d1));
            checkVal("ex_in_b",    ex_in_b,    m.sb ? m.imm : modelFwd(m.rs2, m.d2));
            checkVal("ex_rs2_fwd", ex_rs2_fwd, modelFwd(m.rs2, m.d2));
            checkVal("ex_op_sel",  {28'd0, ex_op_sel},  {28'd0, m.op});
            checkVal("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, m.rd});
        end
    endtask

    // Advances one rising edge and moves the model to the EX contents
    // that follow from the inputs presented this cycle.
    task automatic clockEdge();
        ex_model_t nm;
        nm = m;
        if (rst) begin
            nm = '{known: 1'b1, valid: 1'b0, rs1: '0, rs2: '0, rd: '0, d1: '0, d2: '0,
                   imm: '0, pc: '0, sa: 1'b0, sb: 1'b0, we: 1'b0, ld: 1'b0, op: '0};
        end else if (ex_hold) begin
            nm.d1 = modelFwd(m.rs1, m.d1);
            nm.d2 = modelFwd(m.rs2, m.d2);
        end else if (flush || modelLoadUse()) begin
            nm.valid = 1'b0;
            nm.known = 1'b0;
        end else begin
            nm = '{known: 1'b1, valid: id_valid, rs1: id_rs1_addr, rs2: id_rs2_addr,
                   rd: id_rd_addr, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm,
                   pc: id_pc, sa: id_src_a_sel, sb: id_src_b_sel, we: id_rd_we,
                   ld: id_is_load, op: id_alu_op};
        end
        @(posedge clk);
        m = nm;
        #1;
    endtask

    task automatic setIdle();
        rst = 1'b0; id_valid = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0;
        id_src_a_sel = 1'b0; id_src_b_sel = 1'b0; id_alu_op = '0;
        id_rd_we = 1'b0; id_is_load = 1'b0;
        mem_rd_addr = '0; mem_rd_we = 1'b0; mem_result = '0;
        wb_rd_addr = '0; wb_rd_we = 1'b0; wb_result = '0;
        ex_hold = 1'b0; flush = 1'b0;
    endtask

    // Random inputs. The small register range makes hazards and forwarding
    // hits frequent, and reset is kept rare.
    task automatic applyStimulus();
        rst          = ($urandom_range(0, 49) == 0);
        id_valid     = ($urandom_range(0, 3) != 0);
        id_rs1_addr  = AW'($urandom_range(0, 7));
        id_rs2_addr  = AW'($urandom_range(0, 7));
        id_rd_addr   = AW'($urandom_range(0, 7));
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_pc        = $urandom;
        id_src_a_sel = ($urandom_range(0, 3) == 0);
        id_src_b_sel = ($urandom_range(0, 2) == 0);
        id_alu_op    = 4'($urandom_range(0, 15));
        id_rd_we     = ($urandom_range(0, 3) != 0);
        id_is_load   = ($urandom_range(0, 2) == 0);
        mem_rd_addr  = AW'($urandom_range(0, 7));
        mem_rd_we    = ($urandom_range(0, 1) == 0);
        mem_result   = $urandom;
        wb_rd_addr   = AW'($urandom_range(0, 7));
        wb_rd_we     = ($urandom_range(0, 1) == 0);
        wb_result    = $urandom;
        ex_hold      = ($urandom_range(0, 4) == 0);
        flush        = ($urandom_range(0, 7) == 0);
    endtask

    // Directed scenarios first, then a randomized run against the model.
    initial begin
        m = '{known: 1'b0, valid: 1'b0, rs1: '0, rs2: '0, rd: '0, d1: '0, d2: '0,
              imm: '0, pc: '0, sa: 1'b0, sb: 1'b0, we: 1'b0, ld: 1'b0, op: '0};
        setIdle();
        #1;

        // Reset with random inputs, then verify that the cleared state shows zeros.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(); rst = 1'b1; ex_hold = 1'b0;
            clockEdge();
        end
        applyStimulus(); rst = 1'b1; ex_hold = 1'b0;
        checkOutput();
        checkVal("rst_valid", {31'd0, ex_valid}, 32'd0);
        checkVal("rst_stall", {31'd0, id_stall}, 32'd0);
        checkVal("rst_in_a", ex_in_a, 32'd0);
        checkVal("rst_in_b", ex_in_b, 32'd0);
        checkVal("rst_rs2_fwd", ex_rs2_fwd, 32'd0);
        clockEdge();

        // ADD x3,x1,x2 with no forwarding.
        setIdle();
        id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rd_addr = 5'd3;
        id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_alu_op = 4'h3; id_rd_we = 1'b1;
        checkOutput();
        clockEdge();
        setIdle();
        checkOutput();
        checkVal("add_in_a", ex_in_a, 32'd5);
        checkVal("add_in_b", ex_in_b, 32'd7);
        checkVal("add_op", {28'd0, ex_op_sel}, 32'd3);
        checkVal("add_valid", {31'd0, ex_valid}, 32'd1);
        clockEdge();

        // MEM takes priority over WB for the same register; WB applies once MEM drops.
        setIdle();
        id_valid = 1'b1; id_rs1_addr = 5'd4; id_rs1_data = 32'd1; id_rd_addr = 5'd9;
        checkOutput();
        clockEdge();
        setIdle();
        ex_hold = 1'b1;
        mem_rd_we = 1'b1; mem_rd_addr = 5'd4; mem_result = 32'hAA;
        wb_rd_we = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'hBB;
        checkOutput();
        checkVal("fwd_mem", ex_in_a, 32'hAA);
        clockEdge();
        mem_rd_we = 1'b0;
        checkOutput();
        checkVal("fwd_wb", ex_in_a, 32'hBB);
        clockEdge();

        // Load-use: a load to x5 in EX and decode reading rs2=x5.
        setIdle();
        id_valid = 1'b1; id_is_load = 1'b1; id_rd_addr = 5'd5; id_rd_we = 1'b1;
        id_rs1_addr = 5'd1; id_rs2_addr = 5'd2;
        checkOutput();
        clockEdge();
        setIdle();
        id_valid = 1'b1; id_rs1_addr = 5'd0; id_rs1_data = 32'h11; id_rs2_addr = 5'd5;
        id_rs2_data = 32'h999; id_rd_addr = 5'd6; id_rd_we = 1'b1; id_alu_op = 4'h2;
        checkOutput();
        checkVal("lu_stall", {31'd0, id_stall}, 32'd1);
        clockEdge();
        mem_rd_we = 1'b1; mem_rd_addr = 5'd5; mem_result = 32'h55;
        checkOutput();
        checkVal("lu_bubble", {31'd0, ex_valid}, 32'd0);
        checkVal("lu_unstall", {31'd0, id_stall}, 32'd0);
        clockEdge();
        checkOutput();
        checkVal("lu_valid", {31'd0, ex_valid}, 32'd1);
        checkVal("lu_in_b", ex_in_b, 32'h55);
        checkVal("lu_rs2_fwd", ex_rs2_fwd, 32'h55);
        clockEdge();

        // x0 is never forwarded.
        setIdle();
        id_valid = 1'b1; id_rd_addr = 5'd1;
        checkOutput();
        clockEdge();
        setIdle();
        mem_rd_we = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hFFFF_FFFF;
        wb_rd_we = 1'b1; wb_rd_addr = 5'd0; wb_result = 32'hFFFF_FFFF;
        checkOutput();
        checkVal("x0_in_a", ex_in_a, 32'd0);
        checkVal("x0_in_b", ex_in_b, 32'd0);
        clockEdge();

        // A hold of 3 cycles keeps a WB value that is presented only in the first cycle.
        setIdle();
        id_valid = 1'b1; id_rs1_addr = 5'd6; id_rs1_data = 32'h10; id_rd_addr = 5'd7;
        checkOutput();
        clockEdge();
        setIdle();
        ex_hold = 1'b1; wb_rd_we = 1'b1; wb_rd_addr = 5'd6; wb_result = 32'h1234;
        checkOutput();
        checkVal("hold_c1", ex_in_a, 32'h1234);
        clockEdge();
        wb_rd_we = 1'b0;
        checkOutput();
        checkVal("hold_c2", ex_in_a, 32'h1234);
        checkVal("hold_stall", {31'd0, id_stall}, 32'd1);
        clockEdge();
        checkOutput();
        checkVal("hold_c3", ex_in_a, 32'h1234);
        clockEdge();

        // A flush with a valid decode leaves EX empty.
        ex_hold = 1'b0; flush = 1'b1; id_valid = 1'b1;
        checkOutput();
        clockEdge();
        setIdle();
        checkOutput();
        checkVal("flush_valid", {31'd0, ex_valid}, 32'd0);
        clockEdge();

        // When hold and flush coincide, hold wins.
        id_valid = 1'b1; id_rd_addr = 5'd2;
        checkOutput();
        clockEdge();
        setIdle();
        ex_hold = 1'b1; flush = 1'b1;
        checkOutput();
        clockEdge();
        setIdle();
        checkOutput();
        checkVal("holdflush_valid", {31'd0, ex_valid}, 32'd1);
        clockEdge();

        // Randomized run.
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            checkOutput();
            clockEdge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
